// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and helpers for the configurable UART transmitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } uart_tx_state_e;

   typedef enum logic [2:0] {
      PAR_NONE  = 3'd0,
      PAR_ODD   = 3'd1,
      PAR_EVEN  = 3'd2,
      PAR_MARK  = 3'd3,
      PAR_SPACE = 3'd4
   } uart_parity_e;

   typedef enum logic [1:0] {
      STOP_1     = 2'd0,
      STOP_1P5   = 2'd1,
      STOP_2     = 2'd2,
      STOP_2_ALT = 2'd3
   } uart_stop_e;

   typedef enum logic [1:0] {
      LEN_5 = 2'd0,
      LEN_6 = 2'd1,
      LEN_7 = 2'd2,
      LEN_8 = 2'd3
   } uart_len_e;

   localparam int c_MAX_CHAR_W = 8;

   function automatic logic [3:0] len_to_bits(input logic [1:0] len);
      return 4'd5 + {2'b00, len};
   endfunction

   // Encodings 5..7 are reserved and behave as "no parity".
   function automatic logic par_enabled(input logic [2:0] mode);
      return (mode == PAR_ODD) || (mode == PAR_EVEN) ||
             (mode == PAR_MARK) || (mode == PAR_SPACE);
   endfunction

   function automatic logic par_bit(input logic [c_MAX_CHAR_W-1:0] data,
                                    input logic [1:0] len,
                                    input logic [2:0] mode);
      logic [c_MAX_CHAR_W-1:0] mask;
      logic                    x;
      mask = 8'hFF >> (4'd8 - len_to_bits(len));
      x    = ^(data & mask);
      case (mode)
         PAR_ODD:  par_bit = ~x;
         PAR_EVEN: par_bit = x;
         PAR_MARK: par_bit = 1'b1;
         default:  par_bit = 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_cfg_if.sv
// ============================================================================
// Module  : uart_tx_cfg_if
// Brief   : Character valid/ready handshake between TX FIFO and transmitter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_cfg_if #(
   parameter int DATA_W = 8
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// ============================================================================
// Module  : uart_bit_timer
// Brief   : Tick-gated counter with programmable terminal count and done pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_bit_timer #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             a_resetn,
   input  logic             i_en,
   input  logic             i_tick,
   input  logic [CNT_W-1:0] i_tc,
   output logic             o_done
);

   logic [CNT_W-1:0] r_cnt;

   // Done fires on the tick that would bring the count to i_tc, so the
   // counter never has to hold the terminal value itself.
   assign o_done = i_en && i_tick && (r_cnt == i_tc - CNT_W'(1));

   always_ff @(posedge clk or negedge a_resetn) begin
      if (!a_resetn) begin
         r_cnt <= '0;
      end else if (!i_en) begin
         r_cnt <= '0;
      end else if (i_tick) begin
         r_cnt <= o_done ? '0 : r_cnt + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_cfg.sv
// ============================================================================
// Module  : uart_tx_cfg
// Brief   : Runtime-configurable UART transmitter with break generation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int OVS          = 16,
   parameter int DATA_W       = 8,
   parameter int BRK_MIN_BITS = 11
) (
   input  logic                clk,
   input  logic                a_resetn,
   input  logic                b_tick,
   uart_tx_cfg_if.slave        s_if,
   input  logic [1:0]          cfg_len,
   input  logic [2:0]          cfg_parity,
   input  logic [1:0]          cfg_stop,
   input  logic                break_req,
   output logic                tx,
   output logic                busy,
   output logic                tx_done
);

   localparam int c_TICK_W = $clog2(2*OVS) + 1;
   localparam int c_BRK_W  = $clog2(BRK_MIN_BITS*OVS + 1);

   localparam logic [c_TICK_W-1:0] c_TC_1   = c_TICK_W'(OVS);
   localparam logic [c_TICK_W-1:0] c_TC_1P5 = c_TICK_W'((3*OVS)/2);
   localparam logic [c_TICK_W-1:0] c_TC_2   = c_TICK_W'(2*OVS);
   localparam logic [c_BRK_W-1:0]  c_TC_BRK = c_BRK_W'(BRK_MIN_BITS*OVS);

   uart_tx_state_e      r_state;
   uart_tx_state_e      w_state_nxt;
   logic                r_tx;
   logic                w_tx_nxt;
   logic                r_tx_done;
   logic                w_tx_done_nxt;
   logic [DATA_W-1:0]   r_shift;
   logic [2:0]          r_bit_cnt;
   logic [2:0]          r_last;
   logic                r_par_en;
   logic                r_par;
   uart_stop_e          r_stop;
   logic                r_brk_met;
   logic                w_accept;
   logic                w_bit_en;
   logic                w_brk_en;
   logic                w_bit_done;
   logic                w_brk_done;
   logic [c_TICK_W-1:0] w_tc;

   assign s_if.s_ready = (r_state == ST_IDLE) && !break_req;
   assign w_accept     = s_if.s_valid && s_if.s_ready;
   assign w_bit_en     = (r_state == ST_START) || (r_state == ST_DATA) ||
                         (r_state == ST_PARITY) || (r_state == ST_STOP);
   assign w_brk_en     = (r_state == ST_BREAK);

   assign tx      = r_tx;
   assign busy    = (r_state != ST_IDLE);
   assign tx_done = r_tx_done;

   always_comb begin
      w_tc = c_TC_1;
      if (r_state == ST_STOP) begin
         case (r_stop)
            STOP_1:   w_tc = c_TC_1;
            STOP_1P5: w_tc = c_TC_1P5;
            default:  w_tc = c_TC_2;
         endcase
      end
   end

   uart_bit_timer #(.CNT_W(c_TICK_W)) u_bit_timer (
      .clk      (clk),
      .a_resetn (a_resetn),
      .i_en     (w_bit_en),
      .i_tick   (b_tick),
      .i_tc     (w_tc),
      .o_done   (w_bit_done)
   );

   uart_bit_timer #(.CNT_W(c_BRK_W)) u_brk_timer (
      .clk      (clk),
      .a_resetn (a_resetn),
      .i_en     (w_brk_en),
      .i_tick   (b_tick),
      .i_tc     (c_TC_BRK),
      .o_done   (w_brk_done)
   );

   // tx is registered, so the next line level is decided alongside the state.
   always_comb begin
      w_state_nxt   = r_state;
      w_tx_nxt      = r_tx;
      w_tx_done_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (break_req) begin
               w_state_nxt = ST_BREAK;
               w_tx_nxt    = 1'b0;
            end else if (s_if.s_valid) begin
               w_state_nxt = ST_START;
               w_tx_nxt    = 1'b0;
            end
         end
         ST_START: begin
            if (w_bit_done) begin
               w_state_nxt = ST_DATA;
               w_tx_nxt    = r_shift[0];
            end
         end
         ST_DATA: begin
            if (w_bit_done) begin
               if (r_bit_cnt != r_last) begin
                  w_tx_nxt = r_shift[1];
               end else if (r_par_en) begin
                  w_state_nxt = ST_PARITY;
                  w_tx_nxt    = r_par;
               end else begin
                  w_state_nxt = ST_STOP;
                  w_tx_nxt    = 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (w_bit_done) begin
               w_state_nxt = ST_STOP;
               w_tx_nxt    = 1'b1;
            end
         end
         ST_STOP: begin
            if (w_bit_done) begin
               w_state_nxt   = ST_IDLE;
               w_tx_nxt      = 1'b1;
               w_tx_done_nxt = 1'b1;
            end
         end
         ST_BREAK: begin
            if (!break_req && (r_brk_met || w_brk_done)) begin
               w_state_nxt = ST_IDLE;
               w_tx_nxt    = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge a_resetn) begin
      if (!a_resetn) begin
         r_state   <= ST_IDLE;
         r_tx      <= 1'b1;
         r_tx_done <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tx      <= w_tx_nxt;
         r_tx_done <= w_tx_done_nxt;
      end
   end

   // Character and framing are captured once so config changes cannot
   // disturb a frame already in flight.
   always_ff @(posedge clk or negedge a_resetn) begin
      if (!a_resetn) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_last    <= '0;
         r_par_en  <= 1'b0;
         r_par     <= 1'b0;
         r_stop    <= STOP_1;
      end else if (w_accept) begin
         r_shift   <= s_if.s_data;
         r_bit_cnt <= '0;
         r_last    <= 3'(len_to_bits(cfg_len) - 4'd1);
         r_par_en  <= par_enabled(cfg_parity);
         r_par     <= par_bit(8'(s_if.s_data), cfg_len, cfg_parity);
         r_stop    <= uart_stop_e'(cfg_stop);
      end else if ((r_state == ST_DATA) && w_bit_done) begin
         r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
         r_bit_cnt <= r_bit_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge a_resetn) begin
      if (!a_resetn) begin
         r_brk_met <= 1'b0;
      end else if (!w_brk_en) begin
         r_brk_met <= 1'b0;
      end else if (w_brk_done) begin
         r_brk_met <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
// ============================================================================
// Module  : tb_uart_tx_cfg
// Brief   : Randomized self-checking bench against a frame-segment model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_cfg;

   localparam int OVS = 16;
   localparam int BRK = 11;

   logic       clk       = 1'b0;
   logic       a_resetn  = 1'b0;
   logic       b_tick    = 1'b0;
   logic       break_req = 1'b0;
   logic [1:0] cfg_len   = 2'd3;
   logic [2:0] cfg_parity = 3'd0;
   logic [1:0] cfg_stop  = 2'd0;
   logic       tx;
   logic       busy;
   logic       tx_done;

   int n_tests = 0;
   int n_fail  = 0;
   int tick_period = 1;
   int tick_ph = 0;
   int seg_lvl[16];
   int seg_tk[16];
   int seg_n;

   uart_tx_cfg_if #(.DATA_W(8)) s_if ();

   uart_tx_cfg #(.OVS(OVS), .DATA_W(8), .BRK_MIN_BITS(BRK)) dut (
      .clk        (clk),
      .a_resetn   (a_resetn),
      .b_tick     (b_tick),
      .s_if       (s_if),
      .cfg_len    (cfg_len),
      .cfg_parity (cfg_parity),
      .cfg_stop   (cfg_stop),
      .break_req  (break_req),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   // period 1: every cycle, 0: random, N: one pulse every N cycles
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (tick_period == 1) begin
            b_tick = 1'b1;
         end else if (tick_period == 0) begin
            b_tick = ($urandom_range(0, 2) == 0);
         end else begin
            b_tick  = (tick_ph == 0);
            tick_ph = (tick_ph + 1) % tick_period;
         end
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic add_seg(input int lvl, input int tk);
      seg_lvl[seg_n] = lvl;
      seg_tk[seg_n]  = tk;
      seg_n++;
   endtask

   // Expected line as a list of (level, b_tick count) segments.
   task automatic build_frame(input logic [7:0] d, input logic [1:0] len,
                              input logic [2:0] par, input logic [1:0] stop);
      int nb;
      int ones;
      seg_n = 0;
      nb    = 5 + int'(len);
      ones  = 0;
      add_seg(0, OVS);
      for (int i = 0; i < nb; i++) begin
         add_seg(int'(d[i]), OVS);
         ones += int'(d[i]);
      end
      case (par)
         3'd1: add_seg((ones % 2 == 0) ? 1 : 0, OVS);
         3'd2: add_seg(ones % 2, OVS);
         3'd3: add_seg(1, OVS);
         3'd4: add_seg(0, OVS);
         default: ;
      endcase
      case (stop)
         2'd0:    add_seg(1, OVS);
         2'd1:    add_seg(1, (3 * OVS) / 2);
         default: add_seg(1, 2 * OVS);
      endcase
   endtask

   task automatic drive_char(input logic [7:0] d, input logic [1:0] len,
                             input logic [2:0] par, input logic [1:0] stop);
      s_if.s_valid = 1'b1;
      s_if.s_data  = d;
      cfg_len      = len;
      cfg_parity   = par;
      cfg_stop     = stop;
   endtask

   // Called at a negedge with the character already driven.
   task automatic check_frame(input logic [7:0] d, input logic [1:0] len,
                              input logic [2:0] par, input logic [1:0] stop,
                              input bit hold, input logic [7:0] nd, input logic [1:0] nlen,
                              input logic [2:0] npar, input logic [1:0] nstop,
                              input bit brk_noise, output int waited, output int ncyc);
      int k;
      int rem;
      build_frame(d, len, par, stop);
      waited = 0;
      ncyc   = 0;
      #1;
      while (!s_if.s_ready && waited < 500) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!s_if.s_ready) begin
         check_val("accept_timeout", 32'(s_if.s_ready), 32'd1);
         return;
      end
      @(negedge clk);
      s_if.s_valid = hold;
      s_if.s_data  = hold ? nd : 8'($urandom);
      cfg_len      = 2'($urandom);
      cfg_parity   = 3'($urandom);
      cfg_stop     = 2'($urandom);
      k   = 0;
      rem = seg_tk[0];
      while (k < seg_n && ncyc < 20000) begin
         check_val($sformatf("frame_seg%0d", k), 32'({tx, busy, tx_done}),
                   32'(seg_lvl[k] * 4 + 2));
         if (ncyc == 10 && brk_noise) break_req = 1'b1;
         if (ncyc == 30) begin
            break_req = 1'b0;
            if (hold) begin
               cfg_len    = nlen;
               cfg_parity = npar;
               cfg_stop   = nstop;
            end else begin
               cfg_len    = 2'($urandom);
               cfg_parity = 3'($urandom);
               cfg_stop   = 2'($urandom);
            end
         end
         if (b_tick) begin
            rem--;
            if (rem == 0) begin
               k++;
               if (k < seg_n) rem = seg_tk[k];
            end
         end
         ncyc++;
         @(negedge clk);
      end
      if (k < seg_n) check_val("frame_timeout", 32'(k), 32'(seg_n));
      check_val("frame_end", 32'({tx, busy, tx_done}), 32'b101);
      check_val("end_ready", 32'(s_if.s_ready), 32'd1);
   endtask

   task automatic run_break(input int hold_cycles, input int exp_low);
      int low;
      int guard;
      bit seen;
      check_val("brk_pre_ready", 32'(s_if.s_ready), 32'd1);
      break_req    = 1'b1;
      s_if.s_valid = 1'b1;
      s_if.s_data  = 8'h55;
      #1;
      check_val("brk_ready_low", 32'(s_if.s_ready), 32'd0);
      @(negedge clk);
      s_if.s_valid = 1'b0;
      low   = 0;
      guard = 0;
      seen  = 1'b0;
      while (guard < 2000) begin
         if (tx_done) seen = 1'b1;
         if (tx == 1'b0 && !s_if.s_ready) begin
            low++;
            if (low == hold_cycles) break_req = 1'b0;
         end else begin
            break;
         end
         @(negedge clk);
         guard++;
      end
      break_req = 1'b0;
      check_val("brk_low_cycles", 32'(low), 32'(exp_low));
      check_val("brk_exit", 32'({tx, s_if.s_ready, busy}), 32'b110);
      check_val("brk_no_done", 32'(seen), 32'd0);
   endtask

   initial begin
      int w;
      int n;
      bit seen;
      logic [7:0] d;
      logic [1:0] len;
      logic [2:0] par;
      logic [1:0] stop;
      s_if.s_valid = 1'b0;
      s_if.s_data  = 8'h00;

      @(negedge clk);
      @(negedge clk);
      check_val("rst_state", 32'({tx, busy, tx_done, s_if.s_ready}), 32'b1001);
      a_resetn = 1'b1;
      @(negedge clk);

      // 8N1 0xA5, one b_tick per cycle
      tick_period = 1;
      drive_char(8'hA5, 2'd3, 3'd0, 2'd0);
      check_frame(8'hA5, 2'd3, 3'd0, 2'd0, 1'b0, 8'h00, 2'd0, 3'd0, 2'd0, 1'b0, w, n);
      check_val("t1_frame_cycles", 32'(n), 32'd160);

      // 7E1 and 7O1 with 0xD3
      drive_char(8'hD3, 2'd2, 3'd2, 2'd0);
      check_frame(8'hD3, 2'd2, 3'd2, 2'd0, 1'b0, 8'h00, 2'd0, 3'd0, 2'd0, 1'b0, w, n);
      drive_char(8'hD3, 2'd2, 3'd1, 2'd0);
      check_frame(8'hD3, 2'd2, 3'd1, 2'd0, 1'b0, 8'h00, 2'd0, 3'd0, 2'd0, 1'b0, w, n);

      // 5-bit, mark, 1.5 stop
      drive_char(8'h1F, 2'd0, 3'd3, 2'd1);
      check_frame(8'h1F, 2'd0, 3'd3, 2'd1, 1'b0, 8'h00, 2'd0, 3'd0, 2'd0, 1'b0, w, n);
      check_val("t3_frame_cycles", 32'(n), 32'd136);

      // back-to-back with slow b_tick and config toggled mid-frame
      tick_period = 4;
      drive_char(8'h5A, 2'd3, 3'd1, 2'd2);
      check_frame(8'h5A, 2'd3, 3'd1, 2'd2, 1'b1, 8'hC6, 2'd1, 3'd2, 2'd0, 1'b0, w, n);
      check_frame(8'hC6, 2'd1, 3'd2, 2'd0, 1'b0, 8'h00, 2'd0, 3'd0, 2'd0, 1'b0, w, n);
      check_val("t4_b2b_gap", 32'(w), 32'd0);

      // break: minimum length, then held beyond minimum
      tick_period = 1;
      run_break(10, BRK * OVS);
      @(negedge clk);
      run_break(300, 300);
      @(negedge clk);

      // reset in the middle of data bit 3
      drive_char(8'h00, 2'd3, 3'd0, 2'd0);
      #1;
      check_val("t6_ready", 32'(s_if.s_ready), 32'd1);
      @(negedge clk);
      s_if.s_valid = 1'b0;
      repeat (69) @(negedge clk);
      check_val("t6_pre_rst", 32'({tx, busy}), 32'b01);
      a_resetn = 1'b0;
      #1;
      check_val("t6_rst_async", 32'({tx, busy, tx_done}), 32'b100);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (tx_done) seen = 1'b1;
      end
      a_resetn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (tx_done) seen = 1'b1;
      end
      check_val("t6_no_done", 32'(seen), 32'd0);
      drive_char(8'h3C, 2'd3, 3'd0, 2'd0);
      check_frame(8'h3C, 2'd3, 3'd0, 2'd0, 1'b0, 8'h00, 2'd0, 3'd0, 2'd0, 1'b0, w, n);

      // randomized frames, including reserved parity codes and break noise
      for (int i = 0; i < 8; i++) begin
         tick_period = $urandom_range(0, 3);
         d    = 8'($urandom);
         len  = 2'($urandom);
         par  = 3'($urandom);
         stop = 2'($urandom);
         drive_char(d, len, par, stop);
         check_frame(d, len, par, stop, 1'b0, 8'h00, 2'd0, 3'd0, 2'd0,
                     1'($urandom_range(0, 1)), w, n);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter and the successor to the fixed-8-bit TX in the AXI-Lite UART controller. It takes one character per valid/ready handshake from the TX FIFO and serialises it LSB-first on tx. Each frame has 5–8 data bits, none/odd/even/mark/space parity and 1, 1.5 or 2 stop bits. It also adds break generation and a frame-done pulse for status/IRQ logic, with bit timing driven by the shared baud-tick generator (b_tick).

Parameters:
OVS, 16, b_tick pulses per bit period; must be even and ≥4
DATA_W, 8, width of s_data (maximum character length)
BRK_MIN_BITS, 11, minimum break length in bit periods

Ports:
clk  in  1  clock
a_resetn  in  1  reset, asynchronous, active-low
b_tick  in  1  oversample enable, one clk wide
s_valid  in  1  character available
s_ready  out  1  transmitter accepts character
s_data  in  DATA_W  character, LSB transmitted first
cfg_len  in  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_parity  in  3  000 none, 001 odd, 010 even, 011 mark(1), 100 space(0); others = none
cfg_stop  in  2  00=1, 01=1.5, 10=2, 11=2 stop bits
break_req  in  1  hold line low (break)
tx  out  1  serial line, idle high
busy  out  1  state != IDLE
tx_done  out  1  one-cycle pulse at end of last stop bit

Behaviour:
- Reset (async) values: tx=1, tx_done=0, busy=0, state=IDLE, all counters 0. s_ready is combinational, so it reads 1 during reset when break_req=0. Asserting reset mid-frame aborts the frame and forces tx=1 immediately.
- s_ready = (state==IDLE) && !break_req. Acceptance happens on s_valid && s_ready.
- On acceptance, latch s_data, cfg_len, cfg_parity and cfg_stop. Config changes mid-frame have no effect on the current frame.
- Compute parity over the cfg_len low bits only.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE → START on acceptance. tx is registered, so tx=0 from the cycle after acceptance.
- Bit period: a tick counter advances only on b_tick. A bit ends on the b_tick that brings the count to OVS; the counter is then cleared. Cycles without b_tick hold every register.
- START: 1 bit period at tx=0, then → DATA.
- DATA: cfg_len bit periods; tx = shift_reg[0], shifting right at each bit end. After the last bit, go to PARITY if parity is enabled, otherwise STOP.
- PARITY: 1 bit period.
  - odd: tx = ~^data
  - even: tx = ^data
  - mark: tx = 1
  - space: tx = 0
  - Then → STOP.
- STOP: tx=1 for OVS, 3*OVS/2 or 2*OVS ticks, per the latched cfg_stop.
  - On the final tick: tx_done=1 for exactly one cycle, state → IDLE.
  - The next acceptance may occur in the cycle after tx_done, giving back-to-back frames with no extra idle.
- IDLE with break_req=1 → BREAK. In BREAK:
  - tx=0 and s_ready=0.
  - Remain in BREAK until break_req=0 AND at least BRK_MIN_BITS*OVS b_ticks have elapsed, then → IDLE with tx=1.
  - No tx_done on exit.
- break_req asserted mid-frame is ignored until the frame completes.
- Simultaneous s_valid and break_req in IDLE: break wins, because s_ready=0.
- Counter widths: tick counter $clog2(2*OVS)+1 bits; break counter sized for BRK_MIN_BITS*OVS. No wrap is permitted before the compare.

Decomposition:
- Package uart_pkg holds:
  - state enum uart_tx_state_e
  - parity encoding enum uart_parity_e
  - stop encoding enum uart_stop_e
  - length encoding plus a function len_to_bits()
  - a parity function par_bit(data, len, mode)
- One sub-module, uart_bit_timer: b_tick-gated counter with a programmable terminal count (OVS, 3*OVS/2, 2*OVS, BRK_MIN_BITS*OVS) and a single-cycle "done" output. It is shared with the planned RX successor.

Test Plan:
1. OVS=16, b_tick every cycle, 8N1, s_data=0xA5 → tx bits 0,1,0,1,0,0,1,0,1,1, each 16 cycles. tx_done pulses 160 cycles after tx falls, and busy drops the same cycle.
2. 7E1, s_data=0xD3 (low 7 bits = 0x53, four ones) → parity bit 0, and bit 7 of the input is not sent. Repeat with odd parity → parity bit 1.
3. 5-bit, mark parity, 1.5 stop, s_data=0x1F → frame 0,1,1,1,1,1,1,1 followed by 24 stop ticks. Total 136 ticks to tx_done.
4. b_tick once every 4 cycles, s_valid held with two characters, cfg toggled mid-frame → both frames use the latched cfg. The second START begins the cycle after the first tx_done.
5. break_req high for 10 cycles, BRK_MIN_BITS=11, b_tick every cycle → tx=0 and s_ready=0 for exactly 176 cycles, then tx=1, s_ready=1, no tx_done.
6. a_resetn pulsed low during DATA bit 3 → tx=1 asynchronously, tx_done is never pulsed. After release, a new frame with 0x3C transmits correctly.
